// File: rtl/score_pkg.sv
// Shared encodings for the end-of-game scoring pass: FSM state codes (also the
// db_estado codes read by the hex-display decoder) and default scoring constants.
package score_pkg;

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] LEITURA = 3'd1;
    localparam logic [2:0] ESPERA  = 3'd2;
    localparam logic [2:0] ACUMULA = 3'd3;
    localparam logic [2:0] PROXIMO = 3'd4;
    localparam logic [2:0] FIM     = 3'd5;

    localparam int PONTOS_INICIAIS_PADRAO = 100;
    localparam int PENALIDADE_PADRAO      = 5;
    localparam int BONUS_PADRAO           = 2;

    function automatic logic estado_ocupado(input logic [2:0] estado);
        return estado != OCIOSO;
    endfunction

endpackage

// File: rtl/score_sat_alu.sv
// Next-score arithmetic: score minus errors*penalty with a floor at zero, or, when
// bonus_en and the round was perfect, score plus bonus capped at the starting score.
module score_sat_alu #(
    parameter int PONTOS_W        = 7,
    parameter int ERRO_W          = 4,
    parameter int PONTOS_INICIAIS = 100,
    parameter int PENALIDADE      = 5,
    parameter int BONUS           = 2
) (
    input  logic [PONTOS_W-1:0] pontos,
    input  logic [ERRO_W-1:0]   erro,
    input  logic                bonus_en,
    output logic [PONTOS_W-1:0] pontos_prox
);

    localparam int PROD_W = PONTOS_W + ERRO_W;

    logic [PROD_W-1:0] produto;
    logic [PONTOS_W:0] soma;

    // The product is kept wide so a large penalty never aliases into a small one.
    always_comb begin
        produto     = PROD_W'(erro) * PROD_W'(PENALIDADE);
        soma        = {1'b0, pontos} + (PONTOS_W + 1)'(BONUS);
        pontos_prox = pontos;
        if (bonus_en && (erro == '0)) begin
            if (soma > (PONTOS_W + 1)'(PONTOS_INICIAIS))
                pontos_prox = PONTOS_W'(PONTOS_INICIAIS);
            else
                pontos_prox = soma[PONTOS_W-1:0];
        end else if (produto >= PROD_W'(pontos)) begin
            pontos_prox = '0;
        end else begin
            pontos_prox = pontos - produto[PONTOS_W-1:0];
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// End-of-game scoring controller: walks MemErro rounds 0..ultima_rodada, four cycles
// per round (three for the last), then pulses pronto. Bonus option: SCORE_SEQUENCER_BONUS_PERFEITA_EN.
module score_sequencer
    import score_pkg::*;
#(
    parameter int ADDR_W          = 4,
    parameter int ERRO_W          = 4,
    parameter int PONTOS_W        = 7,
    parameter int PONTOS_INICIAIS = PONTOS_INICIAIS_PADRAO,
    parameter int PENALIDADE      = PENALIDADE_PADRAO,
    parameter int BONUS           = BONUS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                cancelar,
    input  logic [ADDR_W-1:0]   ultima_rodada,
    input  logic [ERRO_W-1:0]   erro_dado,
    output logic [ADDR_W-1:0]   erro_endereco,
    output logic                erro_leitura,
    output logic [PONTOS_W-1:0] pontos,
    output logic                ocupado,
    output logic                pronto,
    output logic [2:0]          db_estado
);

    logic [2:0]          estado;
    logic [2:0]          estado_prox;
    logic [ADDR_W-1:0]   indice;
    logic [ADDR_W-1:0]   ultima_reg;
    logic [ERRO_W-1:0]   erro_reg;
    logic [PONTOS_W-1:0] pontos_reg;
    logic [PONTOS_W-1:0] pontos_alu;
    logic                abortar;
    logic                bonus_en;

`ifdef SCORE_SEQUENCER_BONUS_PERFEITA_EN
    assign bonus_en = 1'b1;
`else
    assign bonus_en = 1'b0;
`endif

    // Idle ignores cancelar entirely; everywhere else it overrides the walk.
    assign abortar = cancelar && (estado != OCIOSO);

    score_sat_alu #(
        .PONTOS_W        (PONTOS_W),
        .ERRO_W          (ERRO_W),
        .PONTOS_INICIAIS (PONTOS_INICIAIS),
        .PENALIDADE      (PENALIDADE),
        .BONUS           (BONUS)
    ) u_alu (
        .pontos      (pontos_reg),
        .erro        (erro_reg),
        .bonus_en    (bonus_en),
        .pontos_prox (pontos_alu)
    );

    always_comb begin
        estado_prox = estado;
        if (abortar) begin
            estado_prox = OCIOSO;
        end else begin
            case (estado)
                OCIOSO:  if (iniciar) estado_prox = LEITURA;
                LEITURA: estado_prox = ESPERA;
                ESPERA:  estado_prox = ACUMULA;
                ACUMULA: estado_prox = (indice == ultima_reg) ? FIM : PROXIMO;
                PROXIMO: estado_prox = LEITURA;
                FIM:     estado_prox = OCIOSO;
                default: estado_prox = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            indice     <= '0;
            ultima_reg <= '0;
            erro_reg   <= '0;
            pontos_reg <= PONTOS_W'(PONTOS_INICIAIS);
        end else begin
            estado <= estado_prox;
            if (abortar) begin
                indice     <= '0;
                pontos_reg <= PONTOS_W'(PONTOS_INICIAIS);
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (iniciar) begin
                            ultima_reg <= ultima_rodada;
                            indice     <= '0;
                            pontos_reg <= PONTOS_W'(PONTOS_INICIAIS);
                        end
                    end
                    ESPERA:  erro_reg   <= erro_dado;
                    ACUMULA: pontos_reg <= pontos_alu;
                    PROXIMO: indice     <= indice + ADDR_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign erro_endereco = indice;
    assign erro_leitura  = (estado == LEITURA);
    assign pontos        = pontos_reg;
    assign ocupado       = estado_ocupado(estado);
    assign pronto        = (estado == FIM);
    assign db_estado     = estado;

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: table of scoring runs checked through an address/score
// scoreboard, plus hand-written cancel, ignored-start and mid-run reset sequences.
module tb_score_sequencer;

`ifdef SCORE_SEQUENCER_BONUS_PERFEITA_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       cancelar;
    logic [3:0] ultima_rodada;
    logic [3:0] erro_dado;
    logic [3:0] erro_endereco;
    logic       erro_leitura;
    logic [6:0] pontos;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    logic [3:0] mem [16];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0]        ultima;
        logic [15:0][3:0]  erros;
        int                exp_pontos;
    } vec_t;

    vec_t vecs[6];
    int   addr_q[$];
    int   pts_q[$];

    score_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .cancelar      (cancelar),
        .ultima_rodada (ultima_rodada),
        .erro_dado     (erro_dado),
        .erro_endereco (erro_endereco),
        .erro_leitura  (erro_leitura),
        .pontos        (pontos),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // MemErro model: synchronous read, data valid the cycle after erro_leitura.
    always @(posedge clock)
        if (erro_leitura) erro_dado <= mem[erro_endereco];

    task automatic chk(input string nome, input int atual, input int esperado);
        chk_cnt++;
        if (atual == esperado) pass_cnt++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", nome, cyc, atual, esperado);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic int modelo(input int p, input int e);
        if (BONUS_ON && e == 0) return (p + 2 > 100) ? 100 : p + 2;
        if (e * 5 >= p) return 0;
        return p - e * 5;
    endfunction

    function automatic int estado_esperado(input int c, input int ultimo);
        if (c == 0 || c > ultimo) return 0;
        if (c == ultimo) return 5;
        return ((c - 1) % 4) + 1;
    endfunction

    task automatic run(input vec_t v);
        int p;
        int ultimo;
        int npronto;
        for (int i = 0; i < 16; i++) mem[i] = v.erros[i];
        addr_q.delete();
        pts_q.delete();
        p = 100;
        for (int r = 0; r <= int'(v.ultima); r++) begin
            addr_q.push_back(r);
            p = modelo(p, int'(v.erros[r]));
            pts_q.push_back(p);
        end
        ultimo  = 4 * (int'(v.ultima) + 1);
        npronto = 0;
        @(posedge clock);
        #1;
        cyc           = 0;
        ultima_rodada = v.ultima;
        iniciar       = 1'b1;
        @(negedge clock);
        chk("idle_ocupado", int'(ocupado), 0);
        while (cyc < ultimo + 2) begin
            next_cycle();
            iniciar       = 1'b0;
            ultima_rodada = ~v.ultima;
            @(negedge clock);
            chk("ocupado", int'(ocupado), int'(cyc <= ultimo));
            chk("db_estado", int'(db_estado), estado_esperado(cyc, ultimo));
            if (erro_leitura) begin
                if (addr_q.size() == 0) chk("extra_read", 1, 0);
                else chk("erro_endereco", int'(erro_endereco), addr_q.pop_front());
            end
            if (cyc >= 4 && cyc % 4 == 0 && cyc <= ultimo && pts_q.size() > 0)
                chk("pontos_round", int'(pontos), pts_q.pop_front());
            if (pronto) begin
                npronto++;
                chk("pronto_cycle", cyc, ultimo);
                chk("pontos_final", int'(pontos), v.exp_pontos);
            end
        end
        chk("pronto_count", npronto, 1);
        chk("reads_left", addr_q.size(), 0);
        chk("pontos_stable", int'(pontos), v.exp_pontos);
    endtask

    initial begin
        int npronto;
        int nocup;
        reset         = 1'b1;
        iniciar       = 1'b0;
        cancelar      = 1'b0;
        ultima_rodada = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        for (int i = 0; i < 6; i++) vecs[i].erros = '0;
        vecs[0].ultima = 4'd3;  vecs[0].erros[1] = 4'd1; vecs[0].erros[2] = 4'd2;
        vecs[0].exp_pontos = 85;
        vecs[1].ultima = 4'd1;  vecs[1].erros[0] = 4'd15; vecs[1].erros[1] = 4'd15;
        vecs[1].exp_pontos = 0;
        vecs[2].ultima = 4'd0;  vecs[2].erros[0] = 4'd4;
        vecs[2].exp_pontos = 80;
        vecs[3] = vecs[2];
        vecs[4].ultima = 4'd2;  vecs[4].erros[1] = 4'd3;
        vecs[4].exp_pontos = BONUS_ON ? 87 : 85;
        vecs[5].ultima = 4'd15;
        for (int i = 0; i < 16; i++) vecs[5].erros[i] = 4'd1;
        vecs[5].exp_pontos = BONUS_ON ? 20 : 20;

        #12;
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_pontos", int'(pontos), 100);
        chk("rst_leitura", int'(erro_leitura), 0);
        chk("rst_endereco", int'(erro_endereco), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pronto", int'(pronto), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run(vecs[i]);

        // Cancel together with iniciar, after an iniciar mid-run that must be ignored.
        mem[0] = 4'd15; mem[1] = 4'd1; mem[2] = 4'd1; mem[3] = 4'd1;
        @(posedge clock);
        #1;
        cyc = 0; ultima_rodada = 4'd3; iniciar = 1'b1;
        next_cycle(); iniciar = 1'b0;
        next_cycle(); iniciar = 1'b1;
        next_cycle(); iniciar = 1'b0;
        @(negedge clock);
        chk("ign_start_estado", int'(db_estado), 3);
        next_cycle();
        @(negedge clock);
        chk("cancel_pre_pontos", int'(pontos), 25);
        next_cycle();
        next_cycle(); cancelar = 1'b1; iniciar = 1'b1;
        @(negedge clock);
        chk("cancel_pre_estado", int'(db_estado), 2);
        next_cycle(); cancelar = 1'b0; iniciar = 1'b0;
        @(negedge clock);
        chk("cancel_estado", int'(db_estado), 0);
        chk("cancel_ocupado", int'(ocupado), 0);
        chk("cancel_pontos", int'(pontos), 100);
        npronto = 0; nocup = 0;
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            @(negedge clock);
            if (pronto) npronto++;
            if (ocupado) nocup++;
        end
        chk("cancel_no_pronto", npronto, 0);
        chk("cancel_stays_idle", nocup, 0);

        // Asynchronous reset in the middle of a run.
        @(posedge clock);
        #1;
        cyc = 0; ultima_rodada = 4'd3; iniciar = 1'b1;
        next_cycle(); iniciar = 1'b0;
        for (int i = 0; i < 4; i++) next_cycle();
        chk("pre_rst_leitura", int'(erro_leitura), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_estado", int'(db_estado), 0);
        chk("mid_rst_leitura", int'(erro_leitura), 0);
        chk("mid_rst_endereco", int'(erro_endereco), 0);
        chk("mid_rst_pontos", int'(pontos), 100);
        chk("mid_rst_ocupado", int'(ocupado), 0);
        next_cycle();
        reset = 1'b0;
        npronto = 0; nocup = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            @(negedge clock);
            if (pronto) npronto++;
            if (ocupado) nocup++;
        end
        chk("rst_no_pronto", npronto, 0);
        chk("rst_stays_idle", nocup, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Controller that runs the end-of-game scoring pass.
- Walks the per-round error memory (MemErro) from round 0 to the last round played and issues one read per round.
- Deducts a fixed penalty per error from an initial score, saturating at zero.
- Sits beside the game control FSM: started by the game FSM once the last round completes, and returns a one-cycle done pulse with a stable score for display.

Parameters:
- ADDR_W, 4, width of round index / MemErro address
- ERRO_W, 4, width of one MemErro entry (errors in a round)
- PONTOS_W, 7, width of score
- PONTOS_INICIAIS, 100, starting score; also the upper bound of the score
- PENALIDADE, 5, points deducted per error
- BONUS, 2, points added per zero-error round (only with optional feature)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- iniciar  in  1  start pulse; sampled only in OCIOSO
- cancelar  in  1  abort request; honoured in any state except OCIOSO
- ultima_rodada  in  ADDR_W  index of last round to score (inclusive); latched on start
- erro_dado  in  ERRO_W  MemErro read data, valid the cycle after erro_leitura
- erro_endereco  out  ADDR_W  MemErro address
- erro_leitura  out  1  MemErro read enable
- pontos  out  PONTOS_W  registered score
- ocupado  out  1  high in every state except OCIOSO
- pronto  out  1  one-cycle pulse in FIM
- db_estado  out  3  current state code, for debug display

Behaviour:
- Reset values: state OCIOSO, erro_endereco=0, erro_leitura=0, pontos=PONTOS_INICIAIS, ocupado=0, pronto=0, db_estado=0.
- States and codes: OCIOSO=0, LEITURA=1, ESPERA=2, ACUMULA=3, PROXIMO=4, FIM=5.
- OCIOSO: when iniciar=1, latch ultima_rodada, set index to 0 and pontos to PONTOS_INICIAIS, go to LEITURA. Otherwise hold; pontos keeps its last result.
- LEITURA: erro_leitura=1 and erro_endereco=index; go to ESPERA.
- ESPERA: erro_dado is valid this cycle and is registered internally; go to ACUMULA.
- ACUMULA: pontos <= sat0(pontos - erro*PENALIDADE).
  - The product is computed at PONTOS_W+ERRO_W bits.
  - If the product is >= pontos, pontos becomes 0.
  - If index==latched ultima_rodada, go to FIM; otherwise go to PROXIMO.
- PROXIMO: index+1, go to LEITURA. The index never wraps, because the ultima_rodada comparison ends the walk first.
- FIM: pronto=1 for this cycle only; go to OCIOSO.
- Moore outputs only. erro_endereco shows the index in every state.
- Timing: with iniciar sampled at cycle 0, pronto is high in cycle 4*(ultima_rodada+1). The last round skips PROXIMO.
- Simultaneous events and boundaries:
  - cancelar has priority over every transition. It returns to OCIOSO next cycle with no pronto, and pontos is reloaded to PONTOS_INICIAIS.
  - cancelar while in OCIOSO is ignored, and it beats iniciar in the same cycle.
  - iniciar while ocupado=1 is ignored.
  - A change on ultima_rodada during a run has no effect.
  - Asynchronous reset mid-run forces the reset values immediately; no pronto is issued.
  - pontos=0 stays 0 under further penalties.
  - erro_dado=0 leaves pontos unchanged (without the optional feature).

Optional Feature:
- Macro: SCORE_SEQUENCER_BONUS_PERFEITA_EN.
- Defined: in ACUMULA with erro_dado==0, pontos <= min(pontos + BONUS, PONTOS_INICIAIS). Rounds with errors are penalised exactly as above.
- Not defined: zero-error rounds leave pontos unchanged. Ports, states and timing are identical either way.

Decomposition:
- Shared package score_pkg holds:
  - state encoding constants (OCIOSO..FIM, 3-bit)
  - default values of PONTOS_INICIAIS, PENALIDADE, BONUS
  - the db_estado code list shared with the hex-display decoder
- One sub-module, score_sat_alu: purely combinational.
  - Inputs: pontos, erro, and the bonus enable.
  - Output: the next score, applying the multiply-subtract with zero floor and the optional bonus capped at PONTOS_INICIAIS.
  - The FSM, index counter and registers stay in score_sequencer.

Test Plan:
- Nominal: ultima_rodada=3, MemErro={0,1,2,0}, pulse iniciar → erro_endereco visits 0,1,2,3; pronto in cycle 16 only; pontos=85; ocupado high cycles 1..16.
- Floor: ultima_rodada=1, MemErro={15,15} → pontos=25 after round 0, then 0 after round 1; pronto in cycle 8; pontos stays 0.
- Single round with restart: ultima_rodada=0, MemErro={4}, pronto in cycle 4 with pontos=80. A second iniciar then rescores from 100 and gives 80 again.
- Cancel and ignored start: start with ultima_rodada=3, assert cancelar in cycle 6 together with iniciar → OCIOSO in cycle 7, no pronto, pontos=100. An iniciar pulsed in cycle 2 of a run is ignored.
- Reset mid-run: assert reset in cycle 5 of a 4-round run → all outputs at reset values within the same cycle; no pronto after release.
- Bonus (macro defined): MemErro={0,3,0}, ultima_rodada=2 → pontos 100 (capped) → 85 → 87, pronto in cycle 12. Macro undefined: final pontos=85.
